// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction fetch stage.
// Optional feature macro used by fetch_unit: FETCH_SHORT_INSTR_EN.
package fetch_pkg;

  localparam int ADDR_W  = 13;
  localparam int DATA_W  = 8;
  localparam int INSTR_W = 2 * DATA_W;

  // Top two opcode bits that mark a single-byte instruction.
  localparam logic [1:0] SHORT_OPC_PREFIX = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    FETCH_HI,
    FETCH_LO,
    DONE
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter: synchronous active-low reset, load over increment, wraps modulo 2^ADDR_W.
module pc_counter
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] count
);

  logic [ADDR_W-1:0] count_d;
  logic [ADDR_W-1:0] count_q;

  always_comb begin
    // NOTE: default first so every path assigns count_d; otherwise a latch is inferred.
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: the reset lives inside the clocked block, so it is synchronous to clk.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Two-byte instruction fetch FSM in front of the byte-wide main memory.
// Define FETCH_SHORT_INSTR_EN to end a fetch after one byte when the opcode is short.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic               pc_load,
  input  logic [ADDR_W-1:0]  pc_load_val,
  input  logic [ADDR_W-1:0]  dp_addr,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               busy
);

  fetch_state_e       state_d, state_q;
  logic [INSTR_W-1:0] instr_d, instr_q;
  logic               valid_d, valid_q;
  logic               busy_d, busy_q;
  logic               pc_load_en;
  logic               pc_inc;

  pc_counter u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load_en),
    .inc      (pc_inc),
    .load_val (pc_load_val),
    .count    (pc)
  );

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    pc_load_en = 1'b0;
    pc_inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pc_load) begin
          pc_load_en = 1'b1;
        end else if (fetch_req) begin
          state_d = FETCH_HI;
        end
      end
      FETCH_HI: begin
        instr_d[INSTR_W-1:DATA_W] = mem_rdata;
        pc_inc                    = 1'b1;
        state_d                   = FETCH_LO;
`ifdef FETCH_SHORT_INSTR_EN
        if (mem_rdata[DATA_W-1 -: 2] == SHORT_OPC_PREFIX) begin
          instr_d = {mem_rdata, {DATA_W{1'b0}}};
          state_d = DONE;
        end
`endif
      end
      FETCH_LO: begin
        instr_d[DATA_W-1:0] = mem_rdata;
        pc_inc              = 1'b1;
        state_d             = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Valid and busy are registered from the next state so both are clean flop outputs.
    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign mem_addr    = busy_q ? pc : dp_addr;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign busy        = busy_q;

endmodule
